// File: rtl/div_share_arb_pkg.sv
// rtl/div_share_arb_pkg.sv - FSM state type and divider constants shared by the arbiter slice
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;

    // One load cycle plus one cycle per quotient bit.
    localparam int DIV_LAT = DEF_WIDTH + 1;

    localparam logic [DEF_WIDTH-1:0] DBZ_QUOT = '1;

    function automatic int div_lat(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/div_share_arb_if.sv
// rtl/div_share_arb_if.sv - request/response bundle between clients and the shared divider
interface div_share_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quot;
    logic [WIDTH-1:0]      rsp_rem;
    logic                  rsp_dbz;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );

endinterface

// File: rtl/div_share_arb_core.sv
// rtl/div_share_arb_core.sv - iterative unsigned restoring divider, one quotient bit per cycle
module div_core_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);

    // Upper half holds the partial remainder, lower half shifts dividend out and quotient in.
    logic [2*WIDTH-1:0] sr;
    logic [WIDTH-1:0]   div_q;
    logic [CW-1:0]      cnt;
    logic               busy;

    logic [WIDTH:0]     trial_hi;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [2*WIDTH-1:0] sr_next;

    always_comb begin
        trial_hi = sr[2*WIDTH-1:WIDTH-1];
        fits     = trial_hi >= {1'b0, div_q};
        diff     = trial_hi - {1'b0, div_q};
        if (fits) begin
            sr_next = {diff[WIDTH-1:0], sr[WIDTH-2:0], 1'b1};
        end else begin
            sr_next = {sr[2*WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            div_q <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                sr  <= sr_next;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                sr    <= {{WIDTH{1'b0}}, a};
                div_q <= b;
                cnt   <= CW'(WIDTH);
                busy  <= 1'b1;
            end
        end
    end

    assign quot = sr[WIDTH-1:0];
    assign rem  = sr[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/div_share_arb.sv
// rtl/div_share_arb.sv - round-robin front end sharing one divider core among NREQ requesters
module div_share_arb
    import div_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    div_share_arb_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant;
    logic             any_req;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;

    logic             core_start;
    logic             core_done;
    logic [WIDTH-1:0] core_quot;
    logic [WIDTH-1:0] core_rem;

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = last_grant;
        any_req = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (bus.req_valid[idx]) begin
                grant   = IDW'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign sel_a = bus.req_a[grant*WIDTH +: WIDTH];
    assign sel_b = bus.req_b[grant*WIDTH +: WIDTH];

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == IDLE && any_req) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= IDW'(NREQ - 1);
            lat_a         <= '0;
            lat_b         <= '0;
            core_start    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_quot  <= '0;
            bus.rsp_rem   <= '0;
            bus.rsp_dbz   <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant <= grant;
                        bus.rsp_id <= grant;
                        if (sel_b == '0) begin
                            // Zero divisor is answered directly; the core never sees it.
                            bus.rsp_quot  <= '1;
                            bus.rsp_rem   <= sel_a;
                            bus.rsp_dbz   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            lat_a      <= sel_a;
                            lat_b      <= sel_b;
                            core_start <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (core_done) begin
                        bus.rsp_quot  <= core_quot;
                        bus.rsp_rem   <= core_rem;
                        bus.rsp_dbz   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    div_core_seq #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .a     (lat_a),
        .b     (lat_b),
        .done  (core_done),
        .quot  (core_quot),
        .rem   (core_rem)
    );

endmodule
